// File: rtl/line_compose_ctrl_if.sv
// Signal bundle for the line compositor: timing handshake, descriptor RAM, tile port,
// back buffer and the pixel_logic drive/return path.
interface line_compose_ctrl_if #(
   parameter int NUM_LAYERS = 4,
   parameter int TADDR_W    = 16,
   parameter int BB_AW      = 8
);
   localparam int LIDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

   logic               line_start;
   logic               busy;
   logic               line_done;
   logic               layer_rd;
   logic [LIDX_W-1:0]  layer_idx;
   logic [25:0]        layer_desc;
   logic               tile_req;
   logic [TADDR_W-1:0] tile_addr;
   logic               tile_ack;
   logic [31:0]        tile_data;
   logic               bb_rd;
   logic               bb_we;
   logic [BB_AW-1:0]   bb_addr;
   logic [47:0]        bb_rdata;
   logic [47:0]        bb_wdata;
   logic               pl_first;
   logic [1:0]         pl_offset;
   logic [1:0]         pl_line_z;
   logic [4:0]         pl_line_palette;
   logic [31:0]        pl_tile_data;
   logic [11:0]        pl_previous;
   logic [11:0]        pl_previous_out;
   logic [47:0]        pl_pixel_in;
   logic [47:0]        pl_pixel_out;

   modport master (
      input  line_start, layer_desc, tile_ack, tile_data, bb_rdata,
             pl_previous_out, pl_pixel_out,
      output busy, line_done, layer_rd, layer_idx, tile_req, tile_addr,
             bb_rd, bb_we, bb_addr, bb_wdata, pl_first, pl_offset, pl_line_z,
             pl_line_palette, pl_tile_data, pl_previous, pl_pixel_in
   );

   modport slave (
      output line_start, layer_desc, tile_ack, tile_data, bb_rdata,
             pl_previous_out, pl_pixel_out,
      input  busy, line_done, layer_rd, layer_idx, tile_req, tile_addr,
             bb_rd, bb_we, bb_addr, bb_wdata, pl_first, pl_offset, pl_line_z,
             pl_line_palette, pl_tile_data, pl_previous, pl_pixel_in
   );
endinterface

// File: rtl/line_compose_ctrl.sv
// Per-scanline compositor sequencer: clears the back buffer, walks the layer table and
// runs read-modify-write of two back-buffer words per fetched 4bpp tile word.
module line_compose_ctrl #(
   parameter int WORDS_PER_LINE = 160,
   parameter int NUM_LAYERS     = 4,
   parameter int TADDR_W        = 16,
   parameter int BB_AW          = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   line_compose_ctrl_if.master bus
);
   localparam int                LIDX_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
   localparam logic [BB_AW-1:0]  LAST_CLR   = BB_AW'(WORDS_PER_LINE - 1);
   localparam logic [BB_AW-1:0]  LAST_PAIR  = BB_AW'(WORDS_PER_LINE / 2 - 1);
   localparam logic [LIDX_W-1:0] LAST_LAYER = LIDX_W'(NUM_LAYERS - 1);

   typedef enum logic [3:0] {
      IDLE, CLEAR, L_RD, L_LAT, T_REQ, RD0, WR0, RD1, WR1, DONE
   } state_t;

   state_t            state, state_nx;
   logic [LIDX_W-1:0] layer;
   logic [BB_AW-1:0]  idx;
   logic [24:0]       desc;
   logic [31:0]       tile;
   logic [11:0]       prev;
   logic              last_layer;
   logic [BB_AW-1:0]  even_addr;
   logic [BB_AW-1:0]  odd_addr;

   // idx is the clear address in CLEAR and the tile word index afterwards
   assign last_layer = (layer == LAST_LAYER);
   assign even_addr  = {idx[BB_AW-2:0], 1'b0};
   assign odd_addr   = {idx[BB_AW-2:0], 1'b1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.line_start) state_nx = CLEAR;
         CLEAR:   if (idx == LAST_CLR) state_nx = L_RD;
         L_RD:    state_nx = L_LAT;
         L_LAT:   if (bus.layer_desc[25]) state_nx = T_REQ;
                  else if (last_layer)   state_nx = DONE;
                  else                   state_nx = L_RD;
         T_REQ:   if (bus.tile_ack) state_nx = RD0;
         RD0:     state_nx = WR0;
         WR0:     state_nx = RD1;
         RD1:     state_nx = WR1;
         WR1:     if (idx != LAST_PAIR) state_nx = T_REQ;
                  else if (last_layer)  state_nx = DONE;
                  else                  state_nx = L_RD;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         layer <= '0;
         idx   <= '0;
         desc  <= '0;
         tile  <= '0;
         prev  <= '0;
      end else begin
         case (state)
            IDLE:  if (bus.line_start) begin
                      layer <= '0;
                      idx   <= '0;
                   end
            CLEAR: idx <= (idx == LAST_CLR) ? '0 : idx + 1'b1;
            L_LAT: begin
                      desc <= bus.layer_desc[24:0];
                      prev <= '0;
                      idx  <= '0;
                      if (!bus.layer_desc[25] && !last_layer) layer <= layer + 1'b1;
                   end
            T_REQ: if (bus.tile_ack) tile <= bus.tile_data;
            WR1:   begin
                      // carry the tail pixels of this tile word into the next one
                      prev <= bus.pl_previous_out;
                      if (idx != LAST_PAIR)  idx   <= idx + 1'b1;
                      else if (!last_layer)  layer <= layer + 1'b1;
                   end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.busy        = 1'b0;
      bus.line_done   = 1'b0;
      bus.layer_rd    = 1'b0;
      bus.tile_req    = 1'b0;
      bus.bb_rd       = 1'b0;
      bus.bb_we       = 1'b0;
      bus.bb_addr     = '0;
      bus.bb_wdata    = '0;
      bus.pl_first    = 1'b0;
      bus.pl_pixel_in = '0;
      case (state)
         CLEAR: begin
            bus.busy    = 1'b1;
            bus.bb_we   = 1'b1;
            bus.bb_addr = idx;
         end
         L_RD: begin
            bus.busy     = 1'b1;
            bus.layer_rd = 1'b1;
         end
         L_LAT: bus.busy = 1'b1;
         T_REQ: begin
            bus.busy     = 1'b1;
            bus.tile_req = 1'b1;
         end
         RD0: begin
            bus.busy    = 1'b1;
            bus.bb_rd   = 1'b1;
            bus.bb_addr = even_addr;
         end
         WR0: begin
            bus.busy        = 1'b1;
            bus.bb_we       = 1'b1;
            bus.bb_addr     = even_addr;
            bus.bb_wdata    = bus.pl_pixel_out;
            bus.pl_first    = 1'b1;
            bus.pl_pixel_in = bus.bb_rdata;
         end
         RD1: begin
            bus.busy    = 1'b1;
            bus.bb_rd   = 1'b1;
            bus.bb_addr = odd_addr;
         end
         WR1: begin
            bus.busy        = 1'b1;
            bus.bb_we       = 1'b1;
            bus.bb_addr     = odd_addr;
            bus.bb_wdata    = bus.pl_pixel_out;
            bus.pl_pixel_in = bus.bb_rdata;
         end
         DONE: bus.line_done = 1'b1;
         default: ;
      endcase
   end

   assign bus.layer_idx       = layer;
   assign bus.tile_addr       = TADDR_W'(desc[15:0]) + TADDR_W'(idx);
   assign bus.pl_offset       = desc[17:16];
   assign bus.pl_line_palette = desc[22:18];
   assign bus.pl_line_z       = desc[24:23];
   assign bus.pl_tile_data    = tile;
   assign bus.pl_previous     = prev;
endmodule

// File: tb/tb_line_compose_ctrl.sv
// Randomized bench for line_compose_ctrl: behavioural memories and pixel_logic stand-in,
// per-line reference of the composed back buffer, tile address list and cycle count.
module tb_line_compose_ctrl;
   localparam int W    = 4;
   localparam int L    = 2;
   localparam int AW_T = $clog2(W);

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   line_compose_ctrl_if #(.NUM_LAYERS(L), .TADDR_W(16), .BB_AW(8)) bus ();

   line_compose_ctrl #(.WORDS_PER_LINE(W), .NUM_LAYERS(L), .TADDR_W(16), .BB_AW(8)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // pixel_logic stand-in: 11-nibble window {tile, previous}, first/second half, offset shift
   function automatic logic [47:0] pix_fn(input logic [47:0] old, input logic first,
                                          input logic [1:0] off, input logic [1:0] z,
                                          input logic [4:0] pal, input logic [31:0] td,
                                          input logic [11:0] pv);
      logic [43:0] s;
      logic [47:0] r;
      logic [3:0]  nib;
      int          k;
      s = {td, pv};
      r = old;
      for (int p = 0; p < 4; p++) begin
         k   = 3 + (first ? 0 : 4) + p - int'(off);
         nib = s[k*4 +: 4];
         if (!old[8+p] || (nib != 4'd0 && z > old[2*p +: 2])) begin
            r[12+9*p +: 9] = {pal, nib};
            r[8+p]         = 1'b1;
            r[2*p +: 2]    = z;
         end
      end
      return r;
   endfunction

   function automatic logic [25:0] mkd(input logic en, input logic [1:0] z, input logic [4:0] pal,
                                       input logic [1:0] off, input logic [15:0] base);
      return {en, z, pal, off, base};
   endfunction

   assign bus.pl_pixel_out    = pix_fn(bus.pl_pixel_in, bus.pl_first, bus.pl_offset, bus.pl_line_z,
                                       bus.pl_line_palette, bus.pl_tile_data, bus.pl_previous);
   assign bus.pl_previous_out = bus.pl_tile_data[31:20];

   logic [47:0] bb   [W];
   logic [25:0] dtab [L];
   logic [31:0] tmem [64];
   logic        scramble;
   logic        mon_clr;
   int          fixed_dly;

   always @(posedge clk) begin
      if (scramble) for (int j = 0; j < W; j++) bb[j] <= {16'hDEAD, 32'(j * 7 + 1)};
      else if (bus.bb_we) bb[bus.bb_addr[AW_T-1:0]] <= bus.bb_wdata;
      if (bus.bb_rd)    bus.bb_rdata   <= bb[bus.bb_addr[AW_T-1:0]];
      if (bus.layer_rd) bus.layer_desc <= dtab[bus.layer_idx];
   end

   int          busy_cyc, done_cnt, we_cnt, rd_cnt, clr_ok, proto_err, req_cyc, waits;
   int          wcnt, dly;
   logic        req_active = 1'b0;
   logic [15:0] cur_addr;
   logic [15:0] got_req [$];

   // monitor and tile responder, both at the falling edge
   always @(negedge clk) begin
      if (mon_clr) begin
         busy_cyc = 0; done_cnt = 0; we_cnt = 0; rd_cnt = 0; clr_ok = 0;
         proto_err = 0; req_cyc = 0; waits = 0;
         got_req.delete();
      end else if (rst_n) begin
         if (bus.busy) busy_cyc++;
         if (bus.line_done) begin
            done_cnt++;
            if (bus.busy) proto_err++;
         end
         if (bus.bb_we && bus.bb_rd) proto_err++;
         if (bus.bb_we) we_cnt++;
         if (bus.bb_rd) rd_cnt++;
         if ((bus.bb_we || bus.bb_rd) && int'(bus.bb_addr) >= W) proto_err++;
         if (bus.tile_req && (bus.bb_we || bus.bb_rd)) proto_err++;
         if (bus.busy && busy_cyc <= W && bus.bb_we && bus.bb_wdata == 48'd0 &&
             int'(bus.bb_addr) == busy_cyc - 1) clr_ok++;
         if (bus.tile_req) req_cyc++;
      end
      if (bus.tile_req) begin
         if (!req_active) begin
            req_active = 1'b1;
            wcnt       = 0;
            cur_addr   = bus.tile_addr;
            got_req.push_back(bus.tile_addr);
            dly        = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
            waits     += dly;
         end else if (bus.tile_addr != cur_addr) proto_err++;
         if (wcnt == dly) begin
            bus.tile_ack  = 1'b1;
            bus.tile_data = tmem[bus.tile_addr[5:0]];
         end else begin
            bus.tile_ack = 1'b0;
            wcnt++;
         end
      end else begin
         req_active   = 1'b0;
         bus.tile_ack = 1'b0;
      end
   end

   task automatic start_line();
      @(posedge clk); #1;
      scramble = 1'b1; mon_clr = 1'b1;
      @(posedge clk); #1;
      scramble = 1'b0; mon_clr = 1'b0; bus.line_start = 1'b1;
      @(posedge clk); #1;
      bus.line_start = 1'b0;
   endtask

   task automatic run_line(input string tag, input bit mid_start);
      logic [47:0] eb [W];
      logic [15:0] ereq [$];
      logic [15:0] ta, pa;
      logic [11:0] pv;
      logic [25:0] d;
      int          n, nen, exp_lat;
      start_line();
      n = 0;
      while (done_cnt == 0 && n < 1000) begin
         @(posedge clk); #1;
         n++;
         if (mid_start && n == 3) begin
            bus.line_start = 1'b1;
            @(posedge clk); #1;
            bus.line_start = 1'b0;
         end
      end
      chk({tag, ".done_seen"}, (n < 1000), 1'b1);
      repeat (5) @(posedge clk);
      #1;
      for (int j = 0; j < W; j++) eb[j] = '0;
      nen = 0;
      for (int l = 0; l < L; l++) begin
         d = dtab[l];
         if (d[25]) begin
            nen++;
            for (int i = 0; i < W / 2; i++) begin
               ta = d[15:0] + 16'(i);
               pa = ta - 16'd1;
               pv = (i == 0) ? 12'd0 : tmem[pa[5:0]][31:20];
               ereq.push_back(ta);
               eb[2*i]   = pix_fn(eb[2*i],   1'b1, d[17:16], d[24:23], d[22:18], tmem[ta[5:0]], pv);
               eb[2*i+1] = pix_fn(eb[2*i+1], 1'b0, d[17:16], d[24:23], d[22:18], tmem[ta[5:0]], pv);
            end
         end
      end
      exp_lat = W + 2 * L + nen * 5 * (W / 2) + waits;
      chk({tag, ".latency"},   busy_cyc,  exp_lat);
      chk({tag, ".done_cnt"},  done_cnt,  1);
      chk({tag, ".idle_busy"}, bus.busy,  1'b0);
      chk({tag, ".writes"},    we_cnt,    W + W * nen);
      chk({tag, ".reads"},     rd_cnt,    W * nen);
      chk({tag, ".clear"},     clr_ok,    W);
      chk({tag, ".protocol"},  proto_err, 0);
      chk({tag, ".req_cyc"},   req_cyc,   ereq.size() + waits);
      chk({tag, ".nreq"},      got_req.size(), ereq.size());
      for (int k = 0; k < ereq.size() && k < got_req.size(); k++)
         chk($sformatf("%s.taddr%0d", tag, k), got_req[k], ereq[k]);
      for (int j = 0; j < W; j++)
         chk($sformatf("%s.bb%0d", tag, j), bb[j], eb[j]);
   endtask

   task automatic rand_tiles();
      for (int a = 0; a < 64; a++) tmem[a] = $urandom;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0; bus.line_start = 1'b0; scramble = 1'b0; mon_clr = 1'b1; fixed_dly = 0;
      rand_tiles();
      repeat (3) @(posedge clk);
      #1;
      chk("rst.busy",      bus.busy,      1'b0);
      chk("rst.line_done", bus.line_done, 1'b0);
      chk("rst.bb_we",     bus.bb_we,     1'b0);
      chk("rst.bb_rd",     bus.bb_rd,     1'b0);
      chk("rst.tile_req",  bus.tile_req,  1'b0);
      chk("rst.layer_rd",  bus.layer_rd,  1'b0);
      chk("rst.tile_addr", bus.tile_addr, 16'd0);
      rst_n = 1'b1;

      dtab[0] = mkd(1'b0, 2'd1, 5'd3, 2'd0, 16'h0100);
      dtab[1] = mkd(1'b0, 2'd2, 5'd7, 2'd0, 16'h0200);
      run_line("disabled", 1'b0);

      tmem[0] = 32'h87654321; tmem[1] = 32'h0;
      dtab[0] = mkd(1'b1, 2'd1, 5'd3, 2'd0, 16'h0100);
      run_line("layer0", 1'b0);
      chk("layer0.word0", bb[0], {9'h034, 9'h033, 9'h032, 9'h031, 4'hF, 8'h55});

      rand_tiles();
      dtab[1] = mkd(1'b1, 2'd2, 5'd9, 2'd1, 16'h0108);
      run_line("z2_over", 1'b0);
      dtab[1] = mkd(1'b1, 2'd0, 5'd9, 2'd3, 16'h0108);
      run_line("z0_under", 1'b0);

      fixed_dly = 3;
      run_line("ack_dly3", 1'b0);
      fixed_dly = -1;
      run_line("mid_start", 1'b1);

      start_line();
      n = 0;
      while (!(bus.bb_we && bus.pl_first) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rst_wr0.found", (n < 200), 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_wr0.bb_we", bus.bb_we, 1'b0);
      chk("rst_wr0.busy",  bus.busy,  1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_line("after_rst", 1'b0);

      dtab[0] = mkd(1'b1, 2'd3, 5'd1, 2'd2, 16'hFFFF);
      dtab[1] = mkd(1'b0, 2'd0, 5'd0, 2'd0, 16'h0000);
      run_line("wrap", 1'b0);
      if (got_req.size() >= 2) chk("wrap.addr1", got_req[1], 16'h0000);
      else                     chk("wrap.nreq2", got_req.size(), 2);

      for (int t = 0; t < 20; t++) begin
         rand_tiles();
         for (int l = 0; l < L; l++)
            dtab[l] = mkd(($urandom_range(0, 3) != 0), 2'($urandom), 5'($urandom),
                          2'($urandom), 16'($urandom));
         run_line($sformatf("rnd%0d", t), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
